// File: rtl/dino_pkg.sv
// Shared definitions for the dino game blocks: game-state encoding,
// visible-area defaults, 640x480 timing totals and a saturating helper.
package dino_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HIT  = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    localparam int H_VIS_DEF = 640;
    localparam int V_VIS_DEF = 480;
    localparam int H_TOTAL   = 800;
    localparam int V_TOTAL   = 525;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, frame-rate debounce and a
// rising-edge event that coincides with the sampling strobe.
module btn_debounce #(
    parameter int DEB_FRAMES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic sample_en,
    output logic press_evt
);

    logic       sync_1;
    logic       sync_2;
    logic       level;
    logic [2:0] run_cnt;
    logic       differ;
    logic       accept;

    // Bring the asynchronous button into the pixel clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // The level only flips once the same differing sample has been seen on
    // DEB_FRAMES consecutive strobes; any agreeing sample restarts the run.
    assign differ    = (sync_2 != level);
    assign accept    = sample_en && differ && (run_cnt == 3'(DEB_FRAMES - 1));
    assign press_evt = accept && sync_2;

    // Debounced level and consecutive-sample run counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level   <= 1'b0;
            run_cnt <= 3'd0;
        end else if (sample_en) begin
            if (!differ) begin
                run_cnt <= 3'd0;
            end else if (accept) begin
                level   <= sync_2;
                run_cnt <= 3'd0;
            end else begin
                run_cnt <= run_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Game-state controller: frame strobe, pixel-accurate collision counting
// and the IDLE/RUN/HIT/OVER sequencer driving freeze and restart.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, world frozen, waiting for the first press
// RUN   | world moving, overlap pixels counted every frame
// HIT   | collision seen, world frozen for HOLD_FRAMES frames
// OVER  | game over, world frozen, a fresh press starts a new run
module game_state_ctrl
    import dino_pkg::*;
#(
    parameter int H_VIS       = H_VIS_DEF,
    parameter int V_VIS       = V_VIS_DEF,
    parameter int HIT_THRESH  = 4,
    parameter int HOLD_FRAMES = 30,
    parameter int DEB_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic       dino_px,
    input  logic       obst_px,
    input  logic       jump_btn,
    output logic       freeze,
    output logic       restart,
    output logic       frame_tick,
    output logic [1:0] game_state,
    output logic [9:0] overlap_last
);

    logic       tick_cond;
    logic       pix_hit;
    logic       press_evt;
    logic [9:0] ovl_cnt;
    logic [5:0] hold_cnt;
    logic [5:0] hold_nxt;
    logic [1:0] state_nxt;
    logic       restart_nxt;

    assign tick_cond = (hc == 10'd0) && (vc == 10'(V_VIS));
    assign pix_hit   = (hc < 10'(H_VIS)) && (vc < 10'(V_VIS)) &&
                       dino_px && obst_px && (game_state == ST_RUN);

    // One-cycle strobe at the first pixel of vertical blank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_tick <= 1'b0;
        else     frame_tick <= tick_cond;
    end

    btn_debounce #(
        .DEB_FRAMES (DEB_FRAMES)
    ) u_jump_deb (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (jump_btn),
        .sample_en (frame_tick),
        .press_evt (press_evt)
    );

    // Per-frame overlap count; published and cleared at every frame strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovl_cnt      <= 10'd0;
            overlap_last <= 10'd0;
        end else if (frame_tick) begin
            overlap_last <= ovl_cnt;
            ovl_cnt      <= 10'd0;
        end else if (pix_hit) begin
            ovl_cnt <= sat_inc10(ovl_cnt);
        end
    end

    // Next-state decode; the sequencer only moves on frame strobes. In RUN
    // the press is ignored, so a collision always wins over a press.
    always_comb begin
        state_nxt   = game_state;
        hold_nxt    = hold_cnt;
        restart_nxt = 1'b0;
        if (frame_tick) begin
            case (game_state)
                ST_IDLE, ST_OVER: begin
                    if (press_evt) begin
                        state_nxt   = ST_RUN;
                        restart_nxt = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ovl_cnt >= 10'(HIT_THRESH)) begin
                        state_nxt = ST_HIT;
                        hold_nxt  = 6'(HOLD_FRAMES - 1);
                    end
                end
                ST_HIT: begin
                    if (hold_cnt == 6'd0) state_nxt = ST_OVER;
                    else                  hold_nxt  = hold_cnt - 6'd1;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, hold timer and registered controls; freeze tracks the new state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            game_state <= ST_IDLE;
            hold_cnt   <= 6'd0;
            restart    <= 1'b0;
            freeze     <= 1'b1;
        end else begin
            game_state <= state_nxt;
            hold_cnt   <= hold_nxt;
            restart    <= restart_nxt;
            freeze     <= (state_nxt != ST_RUN);
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl. Frames are compressed: only the
// pixels of interest plus the vblank strobe coordinate are driven.
module tb_game_state_ctrl;

    localparam int HIT_THRESH  = 4;
    localparam int HOLD_FRAMES = 30;
    localparam int DEB_FRAMES  = 2;

    logic       clk;
    logic       rst;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       dino_px;
    logic       obst_px;
    logic       jump_btn;
    logic       freeze;
    logic       restart;
    logic       frame_tick;
    logic [1:0] game_state;
    logic [9:0] overlap_last;

    int n_tests = 0;
    int n_fail  = 0;

    // observed values of the last frame
    logic       o_tick, o_tick_after, o_freeze, o_restart, o_restart2;
    logic [1:0] o_state;
    logic [9:0] o_ovl;
    int         o_nticks;

    // reference model (frame-level)
    int m_state, m_lvl, m_streak, m_hit_ticks;
    int e_state, e_ovl;
    bit e_restart, e_freeze;

    int tick_total    = 0;
    int restart_total = 0;

    game_state_ctrl #(
        .HIT_THRESH  (HIT_THRESH),
        .HOLD_FRAMES (HOLD_FRAMES),
        .DEB_FRAMES  (DEB_FRAMES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hc           (hc),
        .vc           (vc),
        .dino_px      (dino_px),
        .obst_px      (obst_px),
        .jump_btn     (jump_btn),
        .freeze       (freeze),
        .restart      (restart),
        .frame_tick   (frame_tick),
        .game_state   (game_state),
        .overlap_last (overlap_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_tick) tick_total++;
        if (restart) restart_total++;
    end

    task automatic model_reset();
        m_state = 0; m_lvl = 0; m_streak = 0; m_hit_ticks = 0;
    endtask

    task automatic drive(input int h, input int v, input bit d, input bit o);
        hc = 10'(h); vc = 10'(v); dino_px = d; obst_px = o;
        @(posedge clk); #1;
    endtask

    // One compressed frame: button held for the whole frame, n_ovl visible
    // overlaps, n_out overlaps outside the visible area, n_solo single-mask
    // pixels, then the vblank strobe coordinate. Updates the model.
    task automatic run_frame(input int n_ovl, input int n_out, input int n_solo, input bit btn);
        int t0;
        bit press;
        bit d;
        t0 = tick_total;
        jump_btn = btn;
        repeat (3) drive(700, 500, 1'b0, 1'b0);
        for (int i = 0; i < n_ovl; i++)
            drive($urandom_range(639), $urandom_range(479), 1'b1, 1'b1);
        for (int i = 0; i < n_out; i++) begin
            if ($urandom_range(1) == 1) drive($urandom_range(1023, 640), $urandom_range(479), 1'b1, 1'b1);
            else                        drive($urandom_range(639), $urandom_range(1023, 481), 1'b1, 1'b1);
        end
        for (int i = 0; i < n_solo; i++) begin
            d = 1'($urandom_range(1));
            drive($urandom_range(639), $urandom_range(479), d, !d);
        end
        drive(0, 480, 1'b0, 1'b0);
        o_tick = frame_tick;
        drive(1, 480, 1'b0, 1'b0);
        o_tick_after = frame_tick;
        o_state  = game_state;
        o_freeze = freeze;
        o_restart = restart;
        o_ovl    = overlap_last;
        drive(2, 480, 1'b0, 1'b0);
        o_restart2 = restart;
        drive(3, 481, 1'b0, 1'b0);
        o_nticks = tick_total - t0;

        // model: overlaps only count while running, capped at 1023
        e_ovl = (m_state == 1) ? ((n_ovl > 1023) ? 1023 : n_ovl) : 0;
        press = 1'b0;
        if (int'(btn) != m_lvl) begin
            m_streak++;
            if (m_streak == DEB_FRAMES) begin
                m_lvl = int'(btn); m_streak = 0; press = btn;
            end
        end else begin
            m_streak = 0;
        end
        e_restart = 1'b0;
        if (m_state == 0 || m_state == 3) begin
            if (press) begin m_state = 1; e_restart = 1'b1; end
        end else if (m_state == 1) begin
            if (e_ovl >= HIT_THRESH) begin m_state = 2; m_hit_ticks = 0; end
        end else begin
            m_hit_ticks++;
            if (m_hit_ticks == HOLD_FRAMES) m_state = 3;
        end
        e_state  = m_state;
        e_freeze = (m_state != 1);
    endtask

    task automatic test_reset();
        rst = 1'b1; jump_btn = 1'b0;
        hc = 10'd700; vc = 10'd500; dino_px = 1'b0; obst_px = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", game_state); end
        n_tests++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL reset_freeze: got %0b expected 1", freeze); end
        n_tests++; if (restart !== 1'b0) begin n_fail++; $display("FAIL reset_restart: got %0b expected 0", restart); end
        n_tests++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %0b expected 0", frame_tick); end
        n_tests++; if (overlap_last !== 10'd0) begin n_fail++; $display("FAIL reset_ovl: got %0d expected 0", overlap_last); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_start();
        for (int f = 1; f <= 3; f++) begin
            run_frame(0, 2, 2, 1'b1);
            n_tests++; if (o_restart !== (f == 2)) begin n_fail++; $display("FAIL start_restart f%0d: got %0b expected %0b", f, o_restart, (f == 2)); end
            n_tests++; if (o_state !== 2'(e_state)) begin n_fail++; $display("FAIL start_state f%0d: got %0d expected %0d", f, o_state, e_state); end
            n_tests++; if (o_restart2 !== 1'b0) begin n_fail++; $display("FAIL start_restart_width f%0d: got %0b expected 0", f, o_restart2); end
        end
        n_tests++; if (o_state !== 2'd1 || o_freeze !== 1'b0) begin n_fail++; $display("FAIL start_run: got state %0d freeze %0b expected 1 0", o_state, o_freeze); end
        n_tests++; if (o_tick !== 1'b1 || o_tick_after !== 1'b0 || o_nticks != 1) begin n_fail++; $display("FAIL start_tick: got %0b/%0b/%0d expected 1/0/1", o_tick, o_tick_after, o_nticks); end
    endtask

    task automatic test_threshold();
        run_frame(HIT_THRESH - 1, 3, 5, 1'b1);
        n_tests++; if (o_ovl !== 10'(HIT_THRESH - 1)) begin n_fail++; $display("FAIL thr_below_ovl: got %0d expected %0d", o_ovl, HIT_THRESH - 1); end
        n_tests++; if (o_state !== 2'd1 || o_freeze !== 1'b0) begin n_fail++; $display("FAIL thr_below_state: got %0d/%0b expected 1/0", o_state, o_freeze); end
        run_frame(HIT_THRESH, 3, 5, 1'b1);
        n_tests++; if (o_ovl !== 10'(HIT_THRESH)) begin n_fail++; $display("FAIL thr_at_ovl: got %0d expected %0d", o_ovl, HIT_THRESH); end
        n_tests++; if (o_state !== 2'd2 || o_freeze !== 1'b1) begin n_fail++; $display("FAIL thr_at_state: got %0d/%0b expected 2/1", o_state, o_freeze); end
    endtask

    task automatic test_hold();
        int exp_st;
        for (int k = 1; k <= HOLD_FRAMES; k++) begin
            run_frame($urandom_range(5), 1, 1, 1'b1);
            exp_st = (k == HOLD_FRAMES) ? 3 : 2;
            n_tests++; if (o_state !== 2'(exp_st) || o_freeze !== 1'b1) begin n_fail++; $display("FAIL hold_state k%0d: got %0d/%0b expected %0d/1", k, o_state, o_freeze, exp_st); end
            n_tests++; if (o_ovl !== 10'd0 || o_restart !== 1'b0) begin n_fail++; $display("FAIL hold_ovl k%0d: got ovl %0d restart %0b expected 0 0", k, o_ovl, o_restart); end
        end
        // held button gives no fresh edge
        for (int k = 0; k < 2; k++) begin
            run_frame(0, 0, 0, 1'b1);
            n_tests++; if (o_state !== 2'd3 || o_restart !== 1'b0) begin n_fail++; $display("FAIL over_held: got %0d/%0b expected 3/0", o_state, o_restart); end
        end
        for (int k = 0; k < 2; k++) begin
            run_frame(0, 0, 0, 1'b0);
            n_tests++; if (o_state !== 2'd3 || o_restart !== 1'b0) begin n_fail++; $display("FAIL over_release: got %0d/%0b expected 3/0", o_state, o_restart); end
        end
        run_frame(0, 0, 0, 1'b1);
        n_tests++; if (o_state !== 2'd3 || o_restart !== 1'b0) begin n_fail++; $display("FAIL over_press1: got %0d/%0b expected 3/0", o_state, o_restart); end
        run_frame(0, 0, 0, 1'b1);
        n_tests++; if (o_state !== 2'd1 || o_restart !== 1'b1 || o_freeze !== 1'b0) begin n_fail++; $display("FAIL over_press2: got %0d/%0b/%0b expected 1/1/0", o_state, o_restart, o_freeze); end
    endtask

    task automatic test_outside();
        run_frame(0, 40, 10, 1'b1);
        n_tests++; if (o_ovl !== 10'd0 || o_state !== 2'd1) begin n_fail++; $display("FAIL outside: got ovl %0d state %0d expected 0 1", o_ovl, o_state); end
        run_frame(2, 40, 10, 1'b1);
        n_tests++; if (o_ovl !== 10'd2 || o_state !== 2'd1) begin n_fail++; $display("FAIL outside_mix: got ovl %0d state %0d expected 2 1", o_ovl, o_state); end
    endtask

    task automatic test_saturation();
        run_frame(1200, 0, 0, 1'b1);
        n_tests++; if (o_ovl !== 10'd1023) begin n_fail++; $display("FAIL sat_ovl: got %0d expected 1023", o_ovl); end
        n_tests++; if (o_state !== 2'd2) begin n_fail++; $display("FAIL sat_state: got %0d expected 2", o_state); end
    endtask

    task automatic test_reset_mid_hit();
        int r0;
        jump_btn = 1'b0;
        for (int i = 0; i < 5; i++) drive(100 + i, 200, 1'b1, 1'b1);
        r0 = restart_total;
        rst = 1'b1;
        #2;
        n_tests++; if (game_state !== 2'd0 || freeze !== 1'b1) begin n_fail++; $display("FAIL midrst_state: got %0d/%0b expected 0/1", game_state, freeze); end
        n_tests++; if (overlap_last !== 10'd0 || restart !== 1'b0) begin n_fail++; $display("FAIL midrst_outs: got ovl %0d restart %0b expected 0 0", overlap_last, restart); end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) drive(200 + i, 201, 1'b1, 1'b1);
        run_frame(0, 0, 0, 1'b0);
        n_tests++; if (o_tick !== 1'b1 || o_nticks != 1) begin n_fail++; $display("FAIL midrst_tick: got %0b/%0d expected 1/1", o_tick, o_nticks); end
        n_tests++; if (o_state !== 2'd0 || o_ovl !== 10'd0) begin n_fail++; $display("FAIL midrst_after: got state %0d ovl %0d expected 0 0", o_state, o_ovl); end
        n_tests++; if (restart_total != r0) begin n_fail++; $display("FAIL midrst_no_restart: got %0d pulses expected 0", restart_total - r0); end
    endtask

    task automatic test_random();
        bit btn;
        btn = 1'b0;
        for (int f = 0; f < 90; f++) begin
            if ($urandom_range(2) == 0) btn = !btn;
            run_frame($urandom_range(6), $urandom_range(4), $urandom_range(4), btn);
            n_tests++; if (o_state !== 2'(e_state) || o_freeze !== e_freeze) begin n_fail++; $display("FAIL rnd_state f%0d: got %0d/%0b expected %0d/%0b", f, o_state, o_freeze, e_state, e_freeze); end
            n_tests++; if (o_restart !== e_restart || o_restart2 !== 1'b0) begin n_fail++; $display("FAIL rnd_restart f%0d: got %0b/%0b expected %0b/0", f, o_restart, o_restart2, e_restart); end
            n_tests++; if (o_ovl !== 10'(e_ovl)) begin n_fail++; $display("FAIL rnd_ovl f%0d: got %0d expected %0d", f, o_ovl, e_ovl); end
            n_tests++; if (o_nticks != 1) begin n_fail++; $display("FAIL rnd_ticks f%0d: got %0d expected 1", f, o_nticks); end
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_start();
        test_threshold();
        test_hold();
        test_outside();
        test_saturation();
        test_reset_mid_hit();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
